// File: rtl/reg_checkpoint_buffer.sv
// ---------------------------------------------------------------------------
// reg_checkpoint_buffer
//
// Circular buffer of architectural register-file snapshots, one entry per
// unresolved speculative branch. It captures the live registers when a
// branch is decoded, frees entries in order as branches resolve correctly,
// and replays the right snapshot into reg_file on a mispredict.
//
// Ports
//   clk                 clock, all state on the rising edge
//   rst_n               asynchronous active-low reset
//   regs_in             live registers (reg_file regs_out), 32 x DATA_WIDTH
//   wb_uses_rw          write-back valid this cycle
//   wb_rw_addr          write-back register address
//   wb_rw_data          write-back data
//   take_ckpt           branch decoded: allocate and capture this cycle
//   ckpt_ready          a take_ckpt this cycle will be accepted
//   ckpt_tag            tag handed out if take_ckpt is accepted (tail)
//   resolve_valid       branch resolution event
//   resolve_tag         tag of the resolving branch
//   resolve_mispredict  1 = mispredict (restore), 0 = correct (free)
//   recover_snapshot    one-cycle strobe telling reg_file to load regs_snapshot
//   regs_snapshot       snapshot being restored, 32 x DATA_WIDTH
//   recover_done        reg_file has finished the load
//   busy                recovery in progress
//   count               live checkpoints, 0..DEPTH
//   err                 one-cycle pulse on a protocol violation
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_checkpoint_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [31:0][`DATA_WIDTH-1:0]        regs_in,
   input  logic                                wb_uses_rw,
   input  logic [4:0]                          wb_rw_addr,
   input  logic [`DATA_WIDTH-1:0]              wb_rw_data,
   input  logic                                take_ckpt,
   output logic                                ckpt_ready,
   output logic [$clog2(DEPTH)-1:0]            ckpt_tag,
   input  logic                                resolve_valid,
   input  logic [$clog2(DEPTH)-1:0]            resolve_tag,
   input  logic                                resolve_mispredict,
   output logic                                recover_snapshot,
   output logic [31:0][`DATA_WIDTH-1:0]        regs_snapshot,
   input  logic                                recover_done,
   output logic                                busy,
   output logic [$clog2(DEPTH):0]              count,
   output logic                                err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECOVER = 2'd1,
      S_WAIT    = 2'd2
   } state_t;

   state_t                         r_state;
   logic [IDX_W-1:0]               r_head;
   logic [IDX_W-1:0]               r_tail;
   logic [IDX_W:0]                 r_count;
   logic                           r_recover;
   logic                           r_busy;
   logic                           r_err;
   logic [31:0][`DATA_WIDTH-1:0]   r_snapshot;

   // Checkpoint storage; no reset so it maps onto block RAM.
   logic [31:0][`DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                           w_idle;
   logic                           w_full;
   logic                           w_misp_req;
   logic                           w_ready;
   logic                           w_take;
   logic [IDX_W-1:0]               w_rel;
   logic                           w_live;
   logic                           w_free;
   logic                           w_misp;
   logic                           w_err;
   logic [31:0][`DATA_WIDTH-1:0]   w_capture;
   logic                           w_unused_r0;

   assign w_idle     = (r_state == S_IDLE);
   assign w_full     = (r_count == FULL_CNT);
   assign w_misp_req = resolve_valid && resolve_mispredict;

   // A mispredict in the same cycle blocks allocation: it flushes the tail.
   assign w_ready = w_idle && !w_full && !w_misp_req;
   assign w_take  = take_ckpt && w_ready;

   // Age of the resolving tag relative to head; live if younger than count.
   assign w_rel  = resolve_tag - r_head;
   assign w_live = ({1'b0, w_rel} < r_count);

   assign w_free = w_idle && resolve_valid && !resolve_mispredict &&
                   (resolve_tag == r_head) && (r_count != '0);
   assign w_misp = w_idle && w_misp_req && w_live;

   assign w_err = (take_ckpt && !w_ready && w_full) ||
                  (resolve_valid && !w_idle) ||
                  (w_idle && resolve_valid && !resolve_mispredict && !w_free) ||
                  (w_idle && w_misp_req && !w_live);

   // Capture image: a same-cycle write-back overrides the stale regs_in
   // value, and r0 is hardwired to zero.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_cap
         if (gi == 0) begin : g_zero
            assign w_capture[gi] = '0;
         end else begin : g_reg
            assign w_capture[gi] = (wb_uses_rw && (wb_rw_addr == 5'(gi))) ?
                                   wb_rw_data : regs_in[gi];
         end
      end
   endgenerate

   // reg_file's r0 output is not needed; entry 0 is always stored as zero.
   assign w_unused_r0 = ^regs_in[0];

   always_ff @(posedge clk) begin
      if (w_take) begin
         r_mem[r_tail] <= w_capture;
      end
   end

   // Pointers, occupancy and the recovery FSM. The snapshot register is
   // loaded directly from the mispredicted entry at the accepting edge, so
   // it is already valid in the cycle recover_snapshot is asserted and no
   // separate restore-tag register is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_recover  <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_snapshot <= '0;
      end else begin
         r_err <= w_err;

         if (w_misp) begin
            // Flush the mispredicted branch and everything younger.
            r_tail  <= resolve_tag;
            r_count <= {1'b0, w_rel};
         end else begin
            if (w_take) begin
               r_tail <= r_tail + 1'b1;
            end
            if (w_free) begin
               r_head <= r_head + 1'b1;
            end
            if (w_take && !w_free) begin
               r_count <= r_count + 1'b1;
            end else if (!w_take && w_free) begin
               r_count <= r_count - 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_misp) begin
                  r_snapshot <= r_mem[resolve_tag];
                  r_recover  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_RECOVER;
               end
            end
            S_RECOVER: begin
               r_recover <= 1'b0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (recover_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_recover <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign ckpt_ready       = w_ready;
   assign ckpt_tag         = r_tail;
   assign recover_snapshot = r_recover;
   assign regs_snapshot    = r_snapshot;
   assign busy             = r_busy;
   assign count            = r_count;
   assign err              = r_err;

endmodule

// File: tb/tb_reg_checkpoint_buffer.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_reg_checkpoint_buffer;

   localparam int DW = `DATA_WIDTH;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [31:0][DW-1:0]    regs_in;
   logic                   wb_uses_rw;
   logic [4:0]             wb_rw_addr;
   logic [DW-1:0]          wb_rw_data;
   logic                   take_ckpt;
   logic                   ckpt_ready;
   logic [1:0]             ckpt_tag;
   logic                   resolve_valid;
   logic [1:0]             resolve_tag;
   logic                   resolve_mispredict;
   logic                   recover_snapshot;
   logic [31:0][DW-1:0]    regs_snapshot;
   logic                   recover_done;
   logic                   busy;
   logic [2:0]             count;
   logic                   err;

   always #5 clk = ~clk;

   reg_checkpoint_buffer #(.DEPTH(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .regs_in            (regs_in),
      .wb_uses_rw         (wb_uses_rw),
      .wb_rw_addr         (wb_rw_addr),
      .wb_rw_data         (wb_rw_data),
      .take_ckpt          (take_ckpt),
      .ckpt_ready         (ckpt_ready),
      .ckpt_tag           (ckpt_tag),
      .resolve_valid      (resolve_valid),
      .resolve_tag        (resolve_tag),
      .resolve_mispredict (resolve_mispredict),
      .recover_snapshot   (recover_snapshot),
      .regs_snapshot      (regs_snapshot),
      .recover_done       (recover_done),
      .busy               (busy),
      .count              (count),
      .err                (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       take;
      logic       rv;
      logic [1:0] rtag;
      logic       exp_ready;
      logic [1:0] exp_tag;
      logic [2:0] exp_count;
      logic       exp_err;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      take_ckpt          = 1'b0;
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
      resolve_tag        = '0;
      wb_uses_rw         = 1'b0;
      wb_rw_addr         = '0;
      wb_rw_data         = '0;
      recover_done       = 1'b0;
   endtask

   task automatic set_regs(input int base);
      for (int i = 0; i < 32; i++) regs_in[i] = DW'(i * 16 + base);
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic take_one();
      take_ckpt = 1'b1;
      tick();
      take_ckpt = 1'b0;
   endtask

   task automatic resolve_ok(input logic [1:0] t);
      resolve_valid = 1'b1;
      resolve_tag   = t;
      tick();
      resolve_valid = 1'b0;
   endtask

   task automatic mispredict(input logic [1:0] t);
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = t;
      tick();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
   endtask

   initial begin
      // take, rv, rtag, exp_ready, exp_tag, exp_count (after edge), exp_err (after edge)
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 3'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'd2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 3'd3, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 3'd4, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd3, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 3'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 3'd1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 3'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 3'd0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 3'd1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'd2, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 3'd2, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 3'd2, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 2'd1, 1'b1, 2'd3, 3'd2, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 3'd3, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'd4, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 3'd3, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 2'd3, 1'b1, 2'd2, 3'd2, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 3'd1, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 3'd0, 1'b0};

      regs_in = '0;
      do_reset();
      set_regs(0);

      // ---- table: allocation, full, in-order free, simultaneous take+free
      for (int v = 0; v < 21; v++) begin
         take_ckpt     = vecs[v].take;
         resolve_valid = vecs[v].rv;
         resolve_tag   = vecs[v].rtag;
         #1;
         chk($sformatf("vec%0d_ready", v), 64'(ckpt_ready), 64'(vecs[v].exp_ready));
         chk($sformatf("vec%0d_tag", v), 64'(ckpt_tag), 64'(vecs[v].exp_tag));
         tick();
         take_ckpt     = 1'b0;
         resolve_valid = 1'b0;
         chk($sformatf("vec%0d_count", v), 64'(count), 64'(vecs[v].exp_count));
         chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
         $display("[TB] vec %0d take=%0b rv=%0b tag=%0d -> count=%0d err=%0b",
                  v, vecs[v].take, vecs[v].rv, vecs[v].rtag, count, err);
      end

      // ---- T1: reset values, capture with write-back bypass, restore path
      do_reset();
      chk("t1_rst_count", 64'(count), 64'd0);
      chk("t1_rst_ready", 64'(ckpt_ready), 64'd1);
      chk("t1_rst_tag", 64'(ckpt_tag), 64'd0);
      chk("t1_rst_busy", 64'(busy), 64'd0);
      chk("t1_rst_recover", 64'(recover_snapshot), 64'd0);
      chk("t1_rst_err", 64'(err), 64'd0);
      chk("t1_rst_snap", 64'(regs_snapshot[5]), 64'd0);
      set_regs(0);
      wb_uses_rw = 1'b1;
      wb_rw_addr = 5'd5;
      wb_rw_data = DW'(32'hDEAD);
      take_one();
      wb_uses_rw = 1'b0;
      chk("t1_count", 64'(count), 64'd1);
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd0;
      #1;
      chk("t1_ready_during_misp", 64'(ckpt_ready), 64'd0);
      chk("t1_recover_before", 64'(recover_snapshot), 64'd0);
      tick();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
      chk("t1_recover", 64'(recover_snapshot), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_count_flush", 64'(count), 64'd0);
      chk("t1_snap_r5", 64'(regs_snapshot[5]), 64'hDEAD);
      chk("t1_snap_r0", 64'(regs_snapshot[0]), 64'd0);
      chk("t1_snap_r7", 64'(regs_snapshot[7]), 64'h70);
      tick();
      chk("t1_recover_one_cycle", 64'(recover_snapshot), 64'd0);
      chk("t1_wait_busy", 64'(busy), 64'd1);
      chk("t1_wait_snap_held", 64'(regs_snapshot[5]), 64'hDEAD);
      tick();
      chk("t1_wait_holds", 64'(busy), 64'd1);
      recover_done = 1'b1;
      #1;
      chk("t1_ready_in_wait", 64'(ckpt_ready), 64'd0);
      tick();
      recover_done = 1'b0;
      #1;
      chk("t1_idle_busy", 64'(busy), 64'd0);
      chk("t1_idle_ready", 64'(ckpt_ready), 64'd1);
      $display("[TB] T1 capture/restore r5=%0h", regs_snapshot[5]);

      // ---- T3: mispredict a middle tag, resolve during recovery
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_regs(k * 256);
         take_one();
      end
      set_regs(32'h9000);
      mispredict(2'd1);
      chk("t3_recover", 64'(recover_snapshot), 64'd1);
      chk("t3_snap_r3", 64'(regs_snapshot[3]), 64'h130);
      chk("t3_snap_r0", 64'(regs_snapshot[0]), 64'd0);
      chk("t3_snap_r31", 64'(regs_snapshot[31]), 64'h2F0);
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_tail", 64'(ckpt_tag), 64'd1);
      tick();
      resolve_ok(2'd0);
      chk("t3_resolve_in_wait_err", 64'(err), 64'd1);
      chk("t3_resolve_in_wait_count", 64'(count), 64'd1);
      recover_done = 1'b1;
      tick();
      recover_done = 1'b0;
      #1;
      chk("t3_ready_after", 64'(ckpt_ready), 64'd1);
      chk("t3_next_tag", 64'(ckpt_tag), 64'd1);
      take_one();
      chk("t3_count_after_take", 64'(count), 64'd2);
      $display("[TB] T3 mispredict tag1 count=%0d", count);

      // ---- T4: wrapped full buffer, flush all, then non-live mispredict
      do_reset();
      set_regs(32'h500);
      for (int k = 0; k < 4; k++) take_one();
      resolve_ok(2'd0);
      resolve_ok(2'd1);
      take_one();
      take_one();
      chk("t4_full_count", 64'(count), 64'd4);
      chk("t4_full_ready", 64'(ckpt_ready), 64'd0);
      mispredict(2'd2);
      chk("t4_flush_count", 64'(count), 64'd0);
      chk("t4_recover", 64'(recover_snapshot), 64'd1);
      chk("t4_snap_r1", 64'(regs_snapshot[1]), 64'h510);
      tick();
      recover_done = 1'b1;
      tick();
      recover_done = 1'b0;
      mispredict(2'd1);
      chk("t4_dead_tag_err", 64'(err), 64'd1);
      chk("t4_dead_tag_busy", 64'(busy), 64'd0);
      chk("t4_dead_tag_recover", 64'(recover_snapshot), 64'd0);
      chk("t4_dead_tag_count", 64'(count), 64'd0);
      $display("[TB] T4 wrapped flush count=%0d", count);

      // ---- T5: take and mispredict in the same cycle
      do_reset();
      set_regs(0);
      take_one();
      take_one();
      take_ckpt          = 1'b1;
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd1;
      #1;
      chk("t5_ready", 64'(ckpt_ready), 64'd0);
      tick();
      clear_in();
      chk("t5_count", 64'(count), 64'd1);
      chk("t5_tail", 64'(ckpt_tag), 64'd1);
      chk("t5_err", 64'(err), 64'd0);
      $display("[TB] T5 take+mispredict count=%0d", count);

      // ---- T6: asynchronous reset during WAIT and during RECOVER
      do_reset();
      set_regs(0);
      take_one();
      take_one();
      mispredict(2'd1);
      tick();
      chk("t6_wait_busy", 64'(busy), 64'd1);
      chk("t6_wait_count", 64'(count), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_wait_rst_busy", 64'(busy), 64'd0);
      chk("t6_wait_rst_count", 64'(count), 64'd0);
      chk("t6_wait_rst_recover", 64'(recover_snapshot), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      take_one();
      mispredict(2'd0);
      chk("t6_rec_recover", 64'(recover_snapshot), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rec_rst_recover", 64'(recover_snapshot), 64'd0);
      chk("t6_rec_rst_busy", 64'(busy), 64'd0);
      chk("t6_rec_rst_snap", 64'(regs_snapshot[7]), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_ready_after_rst", 64'(ckpt_ready), 64'd1);
      $display("[TB] T6 async reset busy=%0b count=%0d", busy, count);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
